// File: rtl/comp_sched_pkg.sv
// comp_sched_pkg: FSM state constants and default widths/latency shared by comparator_scheduler.
package comp_sched_pkg;
    localparam int DEF_CHECK_W = 20;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_CMP_LAT = 2;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] COMP = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] SEL  = 3'd3;
    localparam logic [2:0] CAPT = 3'd4;
    localparam logic [2:0] RESP = 3'd5;
endpackage

// File: rtl/comp_sched_arbiter.sv
// comp_sched_arbiter: combinational one-hot picker; round-robin from ptr+1 with COMP_SCHED_RR_EN,
// otherwise fixed priority with the lowest index winning.
module comp_sched_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
`ifdef COMP_SCHED_RR_EN
    input  logic [IW-1:0]    ptr,
`endif
    output logic [N_REQ-1:0] grant
);
    // Scanning from lowest to highest priority lets the last hit win.
    always_comb begin
        grant = '0;
`ifdef COMP_SCHED_RR_EN
        for (int k = N_REQ; k >= 1; k--)
            if (valid[(int'(ptr) + k) % N_REQ]) grant = N_REQ'(1) << ((int'(ptr) + k) % N_REQ);
`else
        for (int i = N_REQ - 1; i >= 0; i--)
            if (valid[i]) grant = N_REQ'(1) << i;
`endif
    end
endmodule

// File: rtl/comparator_scheduler.sv
// comparator_scheduler: shares the sprite-collision comparator among N_REQ requesters, one query at a time.
// COMP_SCHED_RR_EN selects round-robin arbitration; undefined gives fixed priority (no pointer register).
module comparator_scheduler
    import comp_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CHECK_W = DEF_CHECK_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CMP_LAT = DEF_CMP_LAT,
    localparam int IW     = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*CHECK_W-1:0] req_check,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IW-1:0]            rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [CHECK_W-1:0]       check,
    output logic                     refresh_comp,
    output logic                     refresh_select,
    input  logic [DATA_W-1:0]        read_data,
    output logic                     busy
);
    state_t           state;
    logic [3:0]       cnt;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    widx;
    logic             hs;

    always_comb begin
        widx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) widx = IW'(i);
    end

    assign req_ready      = (state == IDLE) ? grant : '0;
    assign hs             = |req_ready;
    assign refresh_comp   = state == COMP;
    assign refresh_select = state == SEL;
    assign rsp_valid      = state == RESP;
    assign busy           = state != IDLE;

`ifdef COMP_SCHED_RR_EN
    logic [IW-1:0] ptr;

    always_ff @(posedge clk or negedge reset)
        if (!reset) ptr <= IW'(N_REQ - 1);
        else if (hs) ptr <= widx;

    comp_sched_arbiter #(.N_REQ(N_REQ)) u_arb (.valid(req_valid), .ptr(ptr), .grant(grant));
`else
    comp_sched_arbiter #(.N_REQ(N_REQ)) u_arb (.valid(req_valid), .grant(grant));
`endif

    // WAIT lasts CMP_LAT-1 cycles; with CMP_LAT=1 it is skipped entirely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            check    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    state  <= COMP;
                    check  <= req_check[widx*CHECK_W +: CHECK_W];
                    rsp_id <= widx;
                end
                COMP: begin
                    cnt   <= 4'(CMP_LAT - 1);
                    state <= (CMP_LAT == 1) ? SEL : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= SEL;
                end
                SEL:  state <= CAPT;
                CAPT: begin
                    rsp_data <= read_data;
                    state    <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_comparator_scheduler.sv
// tb_comparator_scheduler: random and directed queries against a cycle-count reference model with a response scoreboard.
module tb_comparator_scheduler;
    localparam int N   = 4;
    localparam int CW  = 20;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int IW  = $clog2(N);

    logic            clk = 0;
    logic            reset = 1;
    logic [N-1:0]    req_valid = '0;
    logic [N*CW-1:0] req_check = '0;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready = 1;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic [CW-1:0]   check;
    logic            refresh_comp, refresh_select, busy;
    logic [DW-1:0]   read_data = '0;

    comparator_scheduler #(.N_REQ(N), .CHECK_W(CW), .DATA_W(DW), .CMP_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_check(req_check),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .check(check),
        .refresh_comp(refresh_comp), .refresh_select(refresh_select),
        .read_data(read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q[$];
    bit            seen_head = 0;
    int            cyc = 0, tests = 0, fails = 0;
    int            m_t = -1, m_done = -1, m_ptr = N - 1;
    logic [CW-1:0] m_check = '0;
    bit            pend[N];
    logic [CW-1:0] chk[N];

    function automatic logic [DW-1:0] cmp_fn(logic [CW-1:0] c);
        return (c == 20'hABCDE) ? 32'h0000_0042 : ({c[11:0], c} ^ 32'h5A5A_0F0F);
    endfunction

    function automatic int pick(logic [N-1:0] v, int p);
`ifdef COMP_SCHED_RR_EN
        for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
`else
        for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
        return -1;
    endfunction

    task automatic chk_eq(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals();
        chk_eq("rst_req_ready", req_ready, 0);
        chk_eq("rst_rsp_valid", rsp_valid, 0);
        chk_eq("rst_rsp_id", rsp_id, 0);
        chk_eq("rst_rsp_data", rsp_data, 0);
        chk_eq("rst_check", check, 0);
        chk_eq("rst_refresh_comp", refresh_comp, 0);
        chk_eq("rst_refresh_select", refresh_select, 0);
        chk_eq("rst_busy", busy, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator stand-in: registers the result on refresh_select, otherwise presents junk.
    always @(posedge clk) read_data <= refresh_select ? cmp_fn(check) : DW'($urandom);

    // A query accepted in cycle T is in COMP at T+1, SEL at T+1+LAT, and responds from T+3+LAT.
    task automatic model_step();
        int w;
        bit free;
        logic [N-1:0] er;
        free = (m_t < 0) || (m_done >= 0 && cyc > m_done);
        w = free ? pick(req_valid, m_ptr) : -1;
        er = (w >= 0) ? (N'(1) << w) : '0;
        chk_eq("req_ready", req_ready, er);
        chk_eq("busy", busy, !free);
        chk_eq("refresh_comp", refresh_comp, m_t >= 0 && cyc == m_t + 1);
        chk_eq("refresh_select", refresh_select, m_t >= 0 && cyc == m_t + 1 + LAT);
        chk_eq("check", check, m_check);
        if (w >= 0) begin
            m_check = req_check[w*CW +: CW];
            m_t = cyc;
            m_done = -1;
            m_ptr = w;
            pend[w] = 0;
            q.push_back('{w, cmp_fn(m_check), cyc + 3 + LAT});
        end else if (m_t >= 0 && m_done < 0 && cyc >= m_t + 3 + LAT && rsp_ready) begin
            m_done = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got rsp_valid id %0d expected no response", rsp_id);
                end else begin
                    chk_eq("rsp_id", rsp_id, q[0].id);
                    chk_eq("rsp_data", rsp_data, q[0].data);
                    if (!seen_head) chk_eq("rsp_latency", cyc, q[0].due);
                    seen_head = 1;
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        seen_head = 0;
                    end
                end
            end else if (q.size() > 0 && cyc >= q[0].due) begin
                tests++;
                fails++;
                $display("FAIL rsp_missing: got no rsp_valid at cycle %0d expected by cycle %0d", cyc, q[0].due);
                void'(q.pop_front());
                seen_head = 0;
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_check[i*CW +: CW] = chk[i];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            chk[i] = '0;
        end
        #1 reset = 0;
        repeat (2) @(posedge clk);
        #1 chk_reset_vals();
        reset = 1;

        pend[2] = 1;
        chk[2] = 20'hABCDE;
        repeat (12) begin drive(); tick(); end

        pend[0] = 1; chk[0] = 20'h12345;
        pend[1] = 1; chk[1] = 20'h0F0F0;
        drive(); tick();
        rsp_ready = 0;
        repeat (16) begin drive(); tick(); end
        rsp_ready = 1;
        repeat (12) begin drive(); tick(); end

        repeat (40) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) chk[i] = CW'($urandom);
                pend[i] = 1;
            end
            drive(); tick();
        end
        for (int i = 0; i < N; i++) pend[i] = 0;
        repeat (10) begin drive(); tick(); end

        pend[0] = 1;
        drive(); tick();
        pend[3] = 1;
        chk[3] = 20'h33333;
        drive(); tick();
        pend[3] = 0;
        repeat (10) begin drive(); tick(); end

        pend[0] = 1;
        chk[0] = 20'h0AAAA;
        hit = 0;
        for (int k = 0; k < 30 && !hit; k++) begin
            drive(); tick();
            hit = m_t >= 0 && m_done < 0 && cyc == m_t + 2;
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL reach_wait: got no query in WAIT expected one within 30 cycles");
        end
        #2 reset = 0;
        #1 chk_reset_vals();
        q.delete();
        seen_head = 0;
        m_t = -1;
        m_done = -1;
        m_ptr = N - 1;
        m_check = '0;
        pend[0] = 0;
        pend[1] = 1;
        chk[1] = 20'h11111;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1;
        repeat (10) begin drive(); tick(); end

        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 5) == 0) begin
                    pend[i] = 1;
                    chk[i] = CW'($urandom);
                end else if (pend[i] && $urandom_range(0, 40) == 0) begin
                    pend[i] = 0;
                end
            end
            rsp_ready = $urandom_range(0, 3) != 0;
            drive(); tick();
        end

        for (int i = 0; i < N; i++) pend[i] = 0;
        rsp_ready = 1;
        repeat (20) begin drive(); tick(); end
        chk_eq("drain_queue", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
